free_list_bank: RTL and testbench
=================================

FREE_LIST_BANK -- requirements
Module: free_list_bank

Interface
REQ-001 SHALL have parameter BANK_ID, default 0; the PRF bank index (0..PRF_BANK_COUNT-1) this free list serves.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port enq_valid  input  1  a freed PR in this bank is returned this cycle (ROB commit side).
REQ-005 SHALL have port enq_PR_by_bank  input  LOG_FREE_LIST_LENGTH_PER_BANK (5)  row of the freed PR, PR = {row, bank}.
REQ-006 SHALL have port deq_valid  output  1  a free PR is available.
REQ-007 SHALL have port deq_ready  input  1  rename consumes the offered PR.
REQ-008 SHALL have port deq_PR_by_bank  output  5  row of the offered PR (head entry).
REQ-009 SHALL have port deq_PR  output  LOG_PR_COUNT (7)  full PR index {deq_PR_by_bank, BANK_ID[LOG_PRF_BANK_COUNT-1:0]}.
REQ-010 SHALL have port count  output  LOG_FREE_LIST_LENGTH_PER_BANK+1 (6)  number of free entries, 0..32.
REQ-011 SHALL have port under_threshold  output  1  count < FREE_LIST_LOWER_THRESHOLD (8).
REQ-012 SHALL have port over_threshold  output  1  count >= FREE_LIST_UPPER_THRESHOLD (24).
REQ-013 SHALL have port overflow_error  output  1  sticky flag: enqueue attempted while full.

Function
REQ-014 SHALL implement a FIFO of FREE_LIST_LENGTH_PER_BANK (32) entries, 5 bits each, with 6-bit head/tail pointers (MSB = wrap bit, low 5 bits = index).
REQ-015 SHALL derive count = tail - head (6-bit modular); empty when count==0, full when count==32.
REQ-016 SHALL drive deq_valid = (count != 0) and deq_PR_by_bank = entry[head index], combinationally from registered state.
REQ-017 SHALL dequeue (head+1) on a cycle where deq_valid & deq_ready; deq_ready while deq_valid=0 SHALL have no effect.
REQ-018 SHALL enqueue (write entry[tail index], tail+1) on enq_valid when not full; when full, enq_valid SHALL leave state unchanged and set overflow_error.
REQ-019 SHALL allow simultaneous enqueue and dequeue in one cycle; count unchanged, both pointers advance.
REQ-020 SHALL provide no bypass: an entry enqueued in cycle N is first offered on deq in cycle N+1; enqueue while empty keeps deq_valid=0 that cycle.
REQ-021 SHALL accept enqueue while full combined with a same-cycle dequeue (full is evaluated before the dequeue).
REQ-022 SHALL wrap pointers from index 31 to 0, toggling the wrap bit.
REQ-023 SHALL compute under_threshold/over_threshold combinationally from registered count.

Reset
REQ-024 SHALL on nRST=0 set entry[i] = i+8 for i=0..23 (rows 0..7 hold the AR_COUNT initial mappings), head=0, tail=24, overflow_error=0.
REQ-025 SHALL therefore present after reset: count=24, deq_valid=1, deq_PR_by_bank=8, deq_PR={8,BANK_ID}, under_threshold=0, over_threshold=1.
REQ-026 SHALL abort any in-flight enqueue/dequeue when reset asserts mid-cycle; no partial update survives.
REQ-027 Entries 24..31 SHALL reset to 0 (don't-care content, reset for determinism).

Structure
REQ-028 Sizes and thresholds SHALL come from core_types_pkg (FREE_LIST_LENGTH_PER_BANK, LOG_FREE_LIST_LENGTH_PER_BANK, LOG_PR_COUNT, LOG_PRF_BANK_COUNT, FREE_LIST_*_THRESHOLD); no new package constants required.
REQ-029 SHALL be one flat module, no sub-module; the top-level free list instantiates FREE_LIST_BANK_COUNT copies with BANK_ID 0..3.

Verification
REQ-030 Reset, BANK_ID=2: deq_PR=7'b0100010 (row 8), count=24, over_threshold=1, under_threshold=0.
REQ-031 Drain: deq_ready=1 for 24 cycles -> rows 8..31 in order, then deq_valid=0, count=0, under_threshold=1; extra deq_ready changes nothing.
REQ-032 Empty, enq_valid row 5 in cycle N with deq_ready=1 -> deq_valid=0 in N, deq_valid=1 row 5 in N+1, count=1.
REQ-033 Fill from reset: enqueue rows 0..7 -> count=32; 9th enqueue alone -> count stays 32, overflow_error=1 sticky; enqueue+dequeue while full -> count 32, head and tail advance.
REQ-034 Wrap: 40 cycles of simultaneous enq/deq at count=24 -> count constant 24, dequeue order equals enqueue order across index 31->0.
REQ-035 Reset asserted mid-stream at count=13 -> next cycle matches REQ-025 exactly.

Source files
------------

// File: rtl/core_types_pkg.sv
// core_types_pkg: shared core sizing constants for the physical register file and free lists
package core_types_pkg;
  localparam int PRF_BANK_COUNT                = 4;
  localparam int LOG_PRF_BANK_COUNT            = 2;
  localparam int FREE_LIST_BANK_COUNT          = 4;
  localparam int FREE_LIST_LENGTH_PER_BANK     = 32;
  localparam int LOG_FREE_LIST_LENGTH_PER_BANK = 5;
  localparam int LOG_PR_COUNT                  = 7;
  localparam int AR_COUNT                      = 8;
  localparam int FREE_LIST_LOWER_THRESHOLD     = 8;
  localparam int FREE_LIST_UPPER_THRESHOLD     = 24;
endpackage

// File: rtl/free_list_bank.sv
// free_list_bank: per-bank circular free list of physical register rows
// Ports:
//   CLK, nRST                        clock, asynchronous active-low reset
//   enq_valid, enq_PR_by_bank        return a freed row of this bank
//   deq_valid, deq_ready             offer/consume the head row
//   deq_PR_by_bank, deq_PR           head row and full PR index {row, BANK_ID}
//   count                            free entries, 0..32
//   under_threshold, over_threshold  occupancy watermarks
//   overflow_error                   sticky, set by an enqueue that could not be accepted
module free_list_bank
  import core_types_pkg::*;
#(
  parameter int BANK_ID = 0
) (
  input  logic                                   CLK,
  input  logic                                   nRST,
  input  logic                                   enq_valid,
  input  logic [LOG_FREE_LIST_LENGTH_PER_BANK-1:0] enq_PR_by_bank,
  output logic                                   deq_valid,
  input  logic                                   deq_ready,
  output logic [LOG_FREE_LIST_LENGTH_PER_BANK-1:0] deq_PR_by_bank,
  output logic [LOG_PR_COUNT-1:0]                deq_PR,
  output logic [LOG_FREE_LIST_LENGTH_PER_BANK:0] count,
  output logic                                   under_threshold,
  output logic                                   over_threshold,
  output logic                                   overflow_error
);
  localparam int ROW_W = LOG_FREE_LIST_LENGTH_PER_BANK;
  localparam int PTR_W = ROW_W + 1;
  localparam int INIT  = FREE_LIST_LENGTH_PER_BANK - AR_COUNT;
  localparam logic [LOG_PRF_BANK_COUNT-1:0] BANK = LOG_PRF_BANK_COUNT'(BANK_ID);

  logic [ROW_W-1:0] r_entries [FREE_LIST_LENGTH_PER_BANK];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic             r_overflow;
  logic             w_full;
  logic             w_deq;
  logic             w_enq;

  // pointer MSB is the wrap bit, so the modular difference covers 0..32
  assign count           = r_tail - r_head;
  assign w_full          = count == PTR_W'(FREE_LIST_LENGTH_PER_BANK);
  assign deq_valid       = count != '0;
  assign deq_PR_by_bank  = r_entries[r_head[ROW_W-1:0]];
  assign deq_PR          = {deq_PR_by_bank, BANK};
  assign under_threshold = count < PTR_W'(FREE_LIST_LOWER_THRESHOLD);
  assign over_threshold  = count >= PTR_W'(FREE_LIST_UPPER_THRESHOLD);
  assign overflow_error  = r_overflow;
  assign w_deq           = deq_valid & deq_ready;
  // a same-cycle dequeue frees the slot the enqueue lands in, so full only blocks a lone enqueue
  assign w_enq           = enq_valid & (~w_full | w_deq);

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      // rows 0..AR_COUNT-1 hold the initial architectural mappings and are not free
      for (int i = 0; i < FREE_LIST_LENGTH_PER_BANK; i++)
        r_entries[i] <= i < INIT ? ROW_W'(i + AR_COUNT) : '0;
      r_head     <= '0;
      r_tail     <= PTR_W'(INIT);
      r_overflow <= 1'b0;
    end else begin
      if (w_enq) r_entries[r_tail[ROW_W-1:0]] <= enq_PR_by_bank;
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      if (enq_valid & ~w_enq) r_overflow <= 1'b1;
    end
endmodule

// File: tb/tb_free_list_bank.sv
// tb_free_list_bank: randomized scoreboard bench for free_list_bank against a queue model
module tb_free_list_bank;
  localparam int BANK_ID = 2;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       enq_valid = 1'b0;
  logic [4:0] enq_PR_by_bank = '0;
  logic       deq_valid;
  logic       deq_ready = 1'b0;
  logic [4:0] deq_PR_by_bank;
  logic [6:0] deq_PR;
  logic [5:0] count;
  logic       under_threshold;
  logic       over_threshold;
  logic       overflow_error;

  int passed = 0;
  int total  = 0;

  int mq[$];
  bit ovf;

  free_list_bank #(.BANK_ID(BANK_ID)) dut (
    .CLK(CLK), .nRST(nRST), .enq_valid(enq_valid), .enq_PR_by_bank(enq_PR_by_bank),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_PR_by_bank(deq_PR_by_bank),
    .deq_PR(deq_PR), .count(count), .under_threshold(under_threshold),
    .over_threshold(over_threshold), .overflow_error(overflow_error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int r = 8; r < 32; r++) mq.push_back(r);
    ovf = 1'b0;
  endtask

  // monitor: compares outputs against the model, then applies this cycle's handshake
  initial begin
    model_reset();
    forever begin
      @(negedge CLK);
      if (!nRST) model_reset();
      else begin
        chk("count", count, mq.size());
        chk("deq_valid", deq_valid, mq.size() != 0);
        chk("under_threshold", under_threshold, mq.size() < 8);
        chk("over_threshold", over_threshold, mq.size() >= 24);
        chk("overflow_error", overflow_error, ovf);
        if (mq.size() != 0) begin
          chk("deq_PR_by_bank", deq_PR_by_bank, mq[0]);
          chk("deq_PR", deq_PR, mq[0] * 4 + BANK_ID);
        end
        if (deq_ready && mq.size() != 0) void'(mq.pop_front());
        if (enq_valid) begin
          if (mq.size() < 32) mq.push_back(enq_PR_by_bank);
          else ovf = 1'b1;
        end
      end
    end
  end

  task automatic step(input logic e, input logic [4:0] r, input logic d);
    enq_valid = e;
    enq_PR_by_bank = r;
    deq_ready = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  int pe[4] = '{80, 20, 60, 50};
  int pd[4] = '{20, 80, 50, 90};

  initial begin
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b1);
    step(1'b1, 5'd5, 1'b1);
    step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 5'(i), 1'b0);
    step(1'b1, 5'd9, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 5'(20 + i), 1'b1);
    step(1'b1, 5'd3, 1'b0);
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 5'($urandom_range(0, 31)), 1'b1);
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 400; i++)
        step($urandom_range(0, 99) < pe[s], 5'($urandom_range(0, 31)),
             $urandom_range(0, 99) < pd[s]);
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b0);
    enq_valid = 1'b1;
    enq_PR_by_bank = 5'd17;
    deq_ready = 1'b1;
    #2;
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    nRST = 1'b1;
    step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b1);
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
